// File: rtl/ninjakun_shram_arb_pkg.sv
// Shared definitions for the Ninjakun shared-RAM arbiter: board variants,
// arbiter state codes and the shared-RAM window prefixes (AD[15:11]).
package ninjakun_shram_arb_pkg;

    // Board variants
    localparam logic [1:0] HW_NINJAKUN = 2'd0;
    localparam logic [1:0] HW_RAIDERS5 = 2'd1;
    localparam logic [1:0] HW_PKUNWAR  = 2'd2;
    localparam logic [1:0] HW_NOVA2001 = 2'd3;

    // Arbiter state codes
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // Shared-RAM window prefixes, compared against AD[15:11]
    localparam logic [4:0] SHWIN_DEF = 5'b11100;
    localparam logic [4:0] SHWIN_R5  = 5'b10100;
    localparam logic [4:0] SHWIN_PK  = 5'b11000;

endpackage

// File: rtl/ninjakun_shram_win.sv
// Shared-RAM window decode for one CPU port. The prefix and whether the
// port is connected at all depend on the board variant and the port index.
module ninjakun_shram_win
    import ninjakun_shram_arb_pkg::*;
#(
    parameter int AW  = 16,
    parameter int IDX = 0
) (
    input  logic [1:0]    hwtype,
    input  logic [AW-1:0] ad,
    output logic          hit
);

    logic [4:0] prefix;
    logic       enabled;

    // Select this port's window prefix and enable for the current board
    always_comb begin
        prefix  = SHWIN_DEF;
        enabled = 1'b1;
        case (hwtype)
            HW_RAIDERS5: begin
                if (IDX == 1) prefix = SHWIN_R5;
            end
            HW_PKUNWAR: begin
                if (IDX == 0) prefix = SHWIN_PK;
                if (IDX == 1) enabled = 1'b0;
            end
            HW_NOVA2001: begin
                if (IDX == 1) enabled = 1'b0;
            end
            default: ;
        endcase
        hit = enabled && (ad[15:11] == prefix);
    end

endmodule

// File: rtl/ninjakun_shram_arb.sv
// N-CPU shared-RAM arbiter: decodes each CPU's window, grants round-robin
// onto one synchronous single-port RAM, stalls CPUs via WAIT and returns
// read data in a per-CPU register.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | pick next pending CPU after ptr, register RAM address/data/WE
// ST_ISSUE   | RAM sees the access; write enable drops at end of cycle
// ST_CAPTURE | RAM read data valid; latch it for the granted CPU, mark done
module ninjakun_shram_arb
    import ninjakun_shram_arb_pkg::*;
#(
    parameter int NCPU  = 2,
    parameter int AW    = 16,
    parameter int RAMAW = 11
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [1:0]        HWTYPE,
    input  logic [NCPU*AW-1:0] CP_AD,
    input  logic [NCPU-1:0]   CP_RD,
    input  logic [NCPU-1:0]   CP_WR,
    input  logic [NCPU*8-1:0] CP_DO,
    output logic [NCPU*8-1:0] CP_DI,
    output logic [NCPU-1:0]   CP_CS,
    output logic [NCPU-1:0]   CP_WAIT,
    output logic [RAMAW-1:0]  RAM_AD,
    output logic [7:0]        RAM_DO,
    output logic              RAM_WE,
    input  logic [7:0]        RAM_DI
);

    localparam int GW = (NCPU > 1) ? $clog2(NCPU) : 1;

    logic [NCPU-1:0] req;
    logic [NCPU-1:0] done;
    logic [NCPU-1:0] pend;
    logic [1:0]      state;
    logic [GW-1:0]   gnt;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   nxt;
    logic            nxt_vld;
    logic            gnt_wr;

    genvar gi;
    generate
        for (gi = 0; gi < NCPU; gi++) begin : g_win
            ninjakun_shram_win #(
                .AW  (AW),
                .IDX (gi)
            ) u_win (
                .hwtype (HWTYPE),
                .ad     (CP_AD[gi*AW +: AW]),
                .hit    (CP_CS[gi])
            );
        end
    endgenerate

    assign req     = CP_CS & (CP_RD | CP_WR);
    assign pend    = req & ~done;
    assign CP_WAIT = pend;

    // Round-robin pick: first pending index after ptr, wrapping around
    always_comb begin
        int idx;
        idx     = 0;
        nxt     = '0;
        nxt_vld = 1'b0;
        // Walk from farthest to nearest so the nearest pending index wins
        for (int k = NCPU; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NCPU;
            if (pend[idx]) begin
                nxt     = GW'(idx);
                nxt_vld = 1'b1;
            end
        end
    end

    // Arbiter FSM and registered RAM interface
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            RAM_WE <= 1'b0;
            RAM_AD <= '0;
            RAM_DO <= '0;
            gnt    <= '0;
            gnt_wr <= 1'b0;
            ptr    <= GW'(NCPU - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (nxt_vld) begin
                        gnt    <= nxt;
                        RAM_AD <= CP_AD[int'(nxt)*AW +: RAMAW];
                        RAM_DO <= CP_DO[int'(nxt)*8 +: 8];
                        RAM_WE <= CP_WR[nxt];
                        gnt_wr <= CP_WR[nxt];
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    RAM_WE <= 1'b0;
                    state  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // ptr tracks the last grant even on an abort so the
                    // aborting CPU does not get priority next round
                    ptr   <= gnt;
                    state <= ST_IDLE;
                end
                default: begin
                    RAM_WE <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-CPU completion flags and read-data registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            done  <= '0;
            CP_DI <= '0;
        end else begin
            for (int i = 0; i < NCPU; i++) begin
                if (!req[i]) done[i] <= 1'b0;
            end
            // A request dropped mid-access is an abort: no data, no done
            if (state == ST_CAPTURE && req[gnt]) begin
                done[gnt] <= 1'b1;
                if (!gnt_wr) CP_DI[int'(gnt)*8 +: 8] <= RAM_DI;
            end
        end
    end

endmodule
